serial_adder: RTL and testbench

- Bit-serial ripple adder that consumes half-adder sum/carry terms one bit per clock.
- Internally, each bit is a full-adder cell built from two half-adder stages, plus a registered carry.
- Adds two WIDTH-bit operands plus a carry-in, LSB first, over WIDTH cycles.
- Returns a parallel sum and carry-out with a start/busy/done handshake. Used where area matters more than latency.

---
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell (two half-adder stages) per clock,
// LSB first, with a start/busy/done handshake and a parallel registered result.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ha1_s, ha1_c, ha2_s, ha2_c;
    logic s_bit, carry_nxt;

    // Full adder as two cascaded half adders on the current LSBs and the carry flop.
    assign ha1_s     = a_sh_q[0] ^ b_sh_q[0];
    assign ha1_c     = a_sh_q[0] & b_sh_q[0];
    assign ha2_s     = ha1_s ^ carry_q;
    assign ha2_c     = ha1_s & carry_q;
    assign s_bit     = ha2_s;
    assign carry_nxt = ha1_c | ha2_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CW'(1);
                // Last bit: publish the accumulator including this cycle's s_bit.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit and 16-bit instances share clock and reset.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  q8  [$];
    logic [16:0] q16 [$];
    logic [8:0]  last8  = '0;
    logic [16:0] last16 = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    // Advances on falling edges until done8 is seen or the budget runs out.
    task automatic wait_done8(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_dut8: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
        end
        n_checks++;
        if ({busy16, done16, cout16, sum16} !== 19'h00000) begin
            n_fail++;
            $display("FAIL reset_dut16: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy16, done16, cout16, sum16);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last8  = '0;
        last16 = '0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] ta [3] = '{8'h35, 8'hFF, 8'hFF};
        logic [7:0] tb [3] = '{8'h4A, 8'h01, 8'hFF};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] exp;
        int cyc, bcnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start8 = 1'b1; a8 = ta[i]; b8 = tb[i]; cin8 = tc[i];
            q8.push_back(9'(ta[i]) + 9'(tb[i]) + 9'(tc[i]));
            @(negedge clk);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            wait_done8(cyc, bcnt);
            n_checks++;
            if (done8 !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_timeout[%0d]: done=%b after %0d cycles, expected 1", i, done8, cyc);
            end
            n_checks++;
            if (cyc !== 8) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d, expected 8", i, cyc);
            end
            n_checks++;
            if (bcnt !== 8) begin
                n_fail++;
                $display("FAIL basic_busy_cycles[%0d]: got %0d, expected 8", i, bcnt);
            end
            exp   = q8.pop_front();
            last8 = exp;
            n_checks++;
            if ({cout8, sum8} !== exp) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got %h, expected %h", i, {cout8, sum8}, exp);
            end
            @(negedge clk);
            n_checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_done_pulse[%0d]: got done=%b busy=%b, expected 0 0", i, done8, busy8);
            end
            n_checks++;
            if ({cout8, sum8} !== exp) begin
                n_fail++;
                $display("FAIL basic_hold[%0d]: got %h, expected %h", i, {cout8, sum8}, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [8:0] exp;
        int cyc, bcnt, dones;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        q8.push_back(9'h030);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h3C; b8 = 8'hC3; cin8 = 1'b1;
        wait_done8(cyc, bcnt);
        n_checks++;
        if (cyc !== 5 || done8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d cycles done=%b, expected 5 and 1", cyc, done8);
        end
        exp   = q8.pop_front();
        last8 = exp;
        n_checks++;
        if ({cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL ignore_result: got %h, expected %h", {cout8, sum8}, exp);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL ignore_extra_done: got %0d pulses, expected 0", dones);
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] exp;
        int cyc, bcnt, dones;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy_before: got %b, expected 1", busy8);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            n_fail++;
            $display("FAIL rstmid_clear: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
        end
        @(negedge clk);
        rst    = 1'b0;
        last8  = '0;
        last16 = '0;
        dones  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0 || {cout8, sum8} !== 9'h000) begin
            n_fail++;
            $display("FAIL rstmid_discard: got %0d pulses result %h, expected 0 pulses result 000", dones, {cout8, sum8});
        end
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        q8.push_back(9'h100);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(cyc, bcnt);
        exp   = q8.pop_front();
        last8 = exp;
        n_checks++;
        if (done8 !== 1'b1 || cyc !== 8 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got done=%b cyc=%0d result %h, expected 1 8 %h", done8, cyc, {cout8, sum8}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp;
        int prev, dones, low;
        for (int k = 0; k < 4; k++) q8.push_back(9'h002);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        prev = 0; dones = 0; low = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy8 !== 1'b1) low++;
            if (done8 === 1'b1) begin
                dones++;
                n_checks++;
                if (i - prev !== (prev == 0 ? 9 : 10)) begin
                    n_fail++;
                    $display("FAIL b2b_spacing: done at cycle %0d after %0d, expected spacing %0d", i, prev, (prev == 0 ? 9 : 10));
                end
                prev = i;
                if (q8.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b2b_unexpected_done: got done at cycle %0d, expected none", i);
                end else begin
                    exp   = q8.pop_front();
                    last8 = exp;
                    n_checks++;
                    if ({cout8, sum8} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result: got %h, expected %h", {cout8, sum8}, exp);
                    end
                end
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (dones !== 4 || q8.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, expected 4", dones);
        end
        n_checks++;
        if (low !== 8) begin
            n_fail++;
            $display("FAIL b2b_busy_low: got %0d cycles, expected 8", low);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [8:0]  exp8;
        logic [16:0] exp16;
        logic got8, got16, stable;
        int cyc;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            start8  = 1'b1; a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
            start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            if (n == 0) begin a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; end
            q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            q16.push_back(17'(a16) + 17'(b16) + 17'(cin16));
            @(negedge clk);
            start8  = 1'b0; a8  = 8'($urandom);  b8  = 8'($urandom);
            start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
            got8 = 1'b0; got16 = 1'b0; stable = 1'b1; cyc = 0;
            while (!(got8 && got16) && cyc < 60) begin
                if (!got8) begin
                    if (done8 === 1'b1) begin
                        got8  = 1'b1;
                        exp8  = q8.pop_front();
                        last8 = exp8;
                        n_checks++;
                        if ({cout8, sum8} !== exp8) begin
                            n_fail++;
                            $display("FAIL rand8_result[%0d]: got %h, expected %h", n, {cout8, sum8}, exp8);
                        end
                    end else if ({cout8, sum8} !== last8) stable = 1'b0;
                end
                if (!got16) begin
                    if (done16 === 1'b1) begin
                        got16  = 1'b1;
                        exp16  = q16.pop_front();
                        last16 = exp16;
                        n_checks++;
                        if ({cout16, sum16} !== exp16) begin
                            n_fail++;
                            $display("FAIL rand16_result[%0d]: got %h, expected %h", n, {cout16, sum16}, exp16);
                        end
                    end else if ({cout16, sum16} !== last16) stable = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            n_checks++;
            if (!(got8 && got16)) begin
                n_fail++;
                $display("FAIL rand_timeout[%0d]: got done8=%b done16=%b, expected both", n, got8, got16);
                q8.delete();
                q16.delete();
            end
            n_checks++;
            if (!stable) begin
                n_fail++;
                $display("FAIL rand_stable[%0d]: result changed before done, expected held value", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
